spi_reg_frame: RTL

Register-access framing engine running directly on the recovered SPI bit clock, downstream of the SPI slave PHY front end. It decodes each chip-select frame into a command byte (R/W plus 7-bit address) and a stream of data bytes. Writes go to a register file as single-edge strobes. Read data is serialised MSb-first onto the MISO bit, and the address auto-increments across a burst. Everything happens in the SPI clock domain, so register writes complete even when the master stops clocking immediately after the last bit.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_byte_shifter.sv | 49 ++++
 rtl/spi_reg_frame.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the SPI register-access framing
//                engine: frame state encoding, command byte layout and
//                byte/bit-counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int BYTE_W     = 8;
    localparam int CMD_RW_BIT = 7;   // 1 = read, 0 = write
    localparam int BIT_CNT_W  = 3;   // counts bit positions within a byte
    localparam int DUMMY_W    = 2;   // enough for up to 3 turnaround bytes

    typedef enum logic [1:0] {
        CMD      = 2'd0,
        WR_DATA  = 2'd1,
        RD_DUMMY = 2'd2,
        RD_DATA  = 2'd3
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_byte_shifter
//  Description : Bit counter and serial-in shifter for one SPI frame.
//                byte_done marks the posedge on which the eighth bit of a
//                byte is present on MOSI; byte_in is the complete byte at
//                that edge (previous seven bits plus the live MOSI bit).
//  Ports       : clk        SPI bit clock (posedge)
//                rst_l      async active-low reset
//                cs_n       chip select; high asynchronously clears state
//                mosi       serial data in, MSb first
//                byte_done  high while the bit counter is on bit 7
//                byte_in    {last 7 captured bits, mosi}
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_l,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              byte_done,
    output logic [BYTE_W-1:0] byte_in
);

    logic [BIT_CNT_W-1:0] bit_cnt;
    // Only the seven most recent bits need storage: the eighth bit is
    // consumed straight from MOSI on the edge that completes the byte.
    logic [BYTE_W-2:0]    shift_in;

    always_ff @(posedge clk or negedge rst_l or posedge cs_n) begin
        if (!rst_l) begin
            bit_cnt  <= '0;
            shift_in <= '0;
        end else if (cs_n) begin
            bit_cnt  <= '0;
            shift_in <= '0;
        end else begin
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            shift_in <= byte_in[BYTE_W-2:0];
        end
    end

    assign byte_done = (bit_cnt == '1);
    assign byte_in   = {shift_in, mosi};

endmodule
`default_nettype wire

// File: rtl/spi_reg_frame.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_frame
//  Description : SPI register-access framing engine on the recovered SPI
//                bit clock. Decodes a command byte (R/W + address), then
//                either strobes data bytes into a register file or
//                serialises register read data MSb-first onto MISO after
//                RD_DUMMY_BYTES turnaround bytes.
//  Config      : SPI_REG_ADDR_INC_EN - when defined, o_Addr increments
//                after each data byte (burst access, wraps modulo
//                2^ADDR_W); when undefined, o_Addr is fixed per frame.
//  Ports       : w_SPI_Clk       SPI bit clock, all logic on posedge
//                i_Rst_L         async active-low reset (clears o_Addr too)
//                i_SPI_CS_n      chip select; high clears frame state
//                i_SPI_MOSI      serial data in
//                o_SPI_MISO_Bit  serial read data (registered)
//                o_SPI_OE        MISO drive enable, read-data phase only
//                o_Addr          current register address
//                o_Wr_En         write strobe (combinational)
//                o_Wr_Data       write data (combinational)
//                o_Rd_En         read/prefetch strobe (combinational)
//                i_Rd_Data       register read data for o_Addr
//                o_Frame_Active  high from first edge after CS fall
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_frame
    import spi_pkg::*;
#(
    parameter int ADDR_W         = 7,
    parameter int RD_DUMMY_BYTES = 1
) (
    input  logic              w_SPI_Clk,
    input  logic              i_Rst_L,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO_Bit,
    output logic              o_SPI_OE,
    output logic [ADDR_W-1:0] o_Addr,
    output logic              o_Wr_En,
    output logic [BYTE_W-1:0] o_Wr_Data,
    output logic              o_Rd_En,
    input  logic [BYTE_W-1:0] i_Rd_Data,
    output logic              o_Frame_Active
);

    localparam logic [DUMMY_W-1:0] DUMMY_LAST = DUMMY_W'(RD_DUMMY_BYTES - 1);

    logic                byte_done;
    logic [BYTE_W-1:0]   byte_in;

    frame_state_t        state;
    frame_state_t        state_nxt;
    logic [DUMMY_W-1:0]  dummy_cnt;
    logic [DUMMY_W-1:0]  dummy_nxt;

    logic                wr_en;
    logic                rd_en;
    logic                addr_load;
    logic                addr_inc;
    logic [ADDR_W-1:0]   addr;
    logic [BYTE_W-1:0]   shift_out;
    logic                frame_active;

    spi_byte_shifter u_shifter (
        .clk       (w_SPI_Clk),
        .rst_l     (i_Rst_L),
        .cs_n      (i_SPI_CS_n),
        .mosi      (i_SPI_MOSI),
        .byte_done (byte_done),
        .byte_in   (byte_in)
    );

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            state     <= CMD;
            dummy_cnt <= '0;
        end else if (i_SPI_CS_n) begin
            state     <= CMD;
            dummy_cnt <= '0;
        end else begin
            state     <= state_nxt;
            dummy_cnt <= dummy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state and strobes. Every decision is taken on the
    // edge that completes a byte.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        dummy_nxt = dummy_cnt;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        addr_load = 1'b0;
        if (byte_done) begin
            case (state)
                CMD: begin
                    addr_load = 1'b1;
                    state_nxt = byte_in[CMD_RW_BIT] ? RD_DUMMY : WR_DATA;
                end
                WR_DATA: begin
                    wr_en = 1'b1;
                end
                RD_DUMMY: begin
                    if (dummy_cnt == DUMMY_LAST) begin
                        // First fetch happens on the last turnaround edge so
                        // the MSb is on MISO before the master samples it.
                        rd_en     = 1'b1;
                        dummy_nxt = '0;
                        state_nxt = RD_DATA;
                    end else begin
                        dummy_nxt = dummy_cnt + DUMMY_W'(1);
                    end
                end
                RD_DATA: begin
                    // Prefetch of the next byte, loaded as the current one
                    // finishes shifting out.
                    rd_en = 1'b1;
                end
                default: begin
                    state_nxt = CMD;
                end
            endcase
        end
    end

`ifdef SPI_REG_ADDR_INC_EN
    assign addr_inc = wr_en | rd_en;
`else
    assign addr_inc = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Address register: survives CS high so the last address remains
    // visible between frames; only reset or a new command changes it.
    // ------------------------------------------------------------------
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            addr <= '0;
        end else if (addr_load) begin
            addr <= byte_in[ADDR_W-1:0];
        end else if (addr_inc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Shift-out register and frame activity flag. Outside the read-data
    // phase shift_out stays zero, which keeps MISO low.
    // ------------------------------------------------------------------
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            shift_out    <= '0;
            frame_active <= 1'b0;
        end else if (i_SPI_CS_n) begin
            shift_out    <= '0;
            frame_active <= 1'b0;
        end else begin
            frame_active <= 1'b1;
            if (rd_en) begin
                shift_out <= i_Rd_Data;
            end else if (state == RD_DATA) begin
                shift_out <= {shift_out[BYTE_W-2:0], 1'b0};
            end
        end
    end

    assign o_SPI_MISO_Bit = shift_out[BYTE_W-1];
    assign o_SPI_OE       = (state == RD_DATA);
    assign o_Addr         = addr;
    assign o_Wr_En        = wr_en;
    assign o_Wr_Data      = byte_in;
    assign o_Rd_En        = rd_en;
    assign o_Frame_Active = frame_active;

endmodule
`default_nettype wire
